// File: rtl/cpu_mul_pkg.sv
// Shared types and helpers for the multiply issue controller.
package cpu_mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_t;

  localparam int LATENCY = 3;

  // The pipe runs MULHSU unsigned; a negative rs1 over-counts the high word by rs2.
  function automatic logic [31:0] mulhsu_fix(input logic [31:0] hi,
                                             input logic        op1_msb,
                                             input logic [31:0] op2);
    return hi - (op1_msb ? op2 : 32'd0);
  endfunction

endpackage

// File: rtl/cpu_mul_sequencer_if.sv
// Request/response handshake bundle between execute, the multiply sequencer and writeback.
interface cpu_mul_sequencer_if #(parameter int TAG_W = 5);
  import cpu_mul_pkg::*;

  logic             i_valid;
  logic             o_ready;
  mul_op_t          i_op;
  logic [31:0]      i_op1;
  logic [31:0]      i_op2;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [31:0]      o_result;
  logic [TAG_W-1:0] o_tag;
  logic             i_flush;
  logic             o_busy;

  modport master (
    output i_valid, i_op, i_op1, i_op2, i_tag, i_ready, i_flush,
    input  o_ready, o_valid, o_result, o_tag, o_busy
  );

  modport slave (
    input  i_valid, i_op, i_op1, i_op2, i_tag, i_ready, i_flush,
    output o_ready, o_valid, o_result, o_tag, o_busy
  );
endinterface

// File: rtl/cpu_mul_pipe.sv
// Free-running 3-stage 32x32->64 multiplier; signedness chosen per operand pair at input.
module cpu_mul_pipe (
  input  logic        i_clock,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_signed,
  output logic [63:0] o_prod
);
  logic [63:0] a_q, a_d, b_q, b_d, p1_q, p1_d, p2_q, p2_d;

  // Operands are extended to 64 bits, so a plain modular product is correct for both signednesses.
  always_comb begin
    a_d  = {{32{i_signed & i_a[31]}}, i_a};
    b_d  = {{32{i_signed & i_b[31]}}, i_b};
    p1_d = a_q * b_q;
    p2_d = p1_q;
  end

  always_ff @(posedge i_clock) begin
    a_q  <= a_d;
    b_q  <= b_d;
    p1_q <= p1_d;
    p2_q <= p2_d;
  end

  assign o_prod = p2_q;
endmodule

// File: rtl/cpu_mul_sequencer.sv
// Issues RV32M multiplies into the pipe, tracks them in a shadow pipeline and
// returns results in order through a credit-protected show-ahead FIFO.
module cpu_mul_sequencer
  import cpu_mul_pkg::*;
#(
  parameter int FIFO_DEPTH = 5,
  parameter int TAG_W      = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  cpu_mul_sequencer_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TOT_W = $clog2(FIFO_DEPTH + LATENCY + 2);

  logic               acc, push, pop;
  logic [63:0]        prod;
  logic [LATENCY-1:0] sh_vld_q, sh_vld_d;
  mul_op_t            sh_op_q  [LATENCY];
  mul_op_t            sh_op_d  [LATENCY];
  logic [TAG_W-1:0]   sh_tag_q [LATENCY];
  logic [TAG_W-1:0]   sh_tag_d [LATENCY];
  logic               sh_msb_q [LATENCY];
  logic               sh_msb_d [LATENCY];
  logic [31:0]        sh_op2_q [LATENCY];
  logic [31:0]        sh_op2_d [LATENCY];
  logic               res_vld_q, res_vld_d;
  logic [31:0]        res_data_q, res_data_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;
  logic [31:0]        mem_res_q [FIFO_DEPTH];
  logic [TAG_W-1:0]   mem_tag_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TOT_W-1:0]   inflight, total;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  cpu_mul_pipe u_pipe (
    .i_clock  (i_clock),
    .i_a      (bus.i_op1),
    .i_b      (bus.i_op2),
    .i_signed (bus.i_op == OP_MULH),
    .o_prod   (prod)
  );

  // Every op past the handshake holds a credit until it leaves the FIFO.
  always_comb begin
    inflight = TOT_W'(res_vld_q);
    for (int i = 0; i < LATENCY; i++) inflight = inflight + TOT_W'(sh_vld_q[i]);
    total = inflight + TOT_W'(count_q);
  end

  assign bus.o_ready = !i_reset && !bus.i_flush && (total < TOT_W'(FIFO_DEPTH));
  assign bus.o_busy  = (total != '0);
  assign acc         = bus.i_valid && bus.o_ready;

  always_comb begin
    sh_vld_d    = {sh_vld_q[LATENCY-2:0], acc};
    sh_op_d[0]  = bus.i_op;
    sh_tag_d[0] = bus.i_tag;
    sh_msb_d[0] = bus.i_op1[31];
    sh_op2_d[0] = bus.i_op2;
    for (int i = 1; i < LATENCY; i++) begin
      sh_op_d[i]  = sh_op_q[i-1];
      sh_tag_d[i] = sh_tag_q[i-1];
      sh_msb_d[i] = sh_msb_q[i-1];
      sh_op2_d[i] = sh_op2_q[i-1];
    end
    res_vld_d = sh_vld_q[LATENCY-1];
    res_tag_d = sh_tag_q[LATENCY-1];
    case (sh_op_q[LATENCY-1])
      OP_MUL:    res_data_d = prod[31:0];
      OP_MULHSU: res_data_d = mulhsu_fix(prod[63:32], sh_msb_q[LATENCY-1], sh_op2_q[LATENCY-1]);
      default:   res_data_d = prod[63:32];
    endcase
    if (bus.i_flush) begin
      sh_vld_d  = '0;
      res_vld_d = 1'b0;
    end
  end

  always_comb begin
    push     = res_vld_q && !bus.i_flush;
    pop      = bus.o_valid && bus.i_ready && !bus.i_flush;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (bus.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sh_vld_q  <= '0;
      res_vld_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      sh_vld_q  <= sh_vld_d;
      res_vld_q <= res_vld_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Payload only matters under a valid bit, so it carries no reset.
  always_ff @(posedge i_clock) begin
    sh_op_q    <= sh_op_d;
    sh_tag_q   <= sh_tag_d;
    sh_msb_q   <= sh_msb_d;
    sh_op2_q   <= sh_op2_d;
    res_data_q <= res_data_d;
    res_tag_q  <= res_tag_d;
    if (push) begin
      mem_res_q[wr_ptr_q] <= res_data_q;
      mem_tag_q[wr_ptr_q] <= res_tag_q;
    end
  end

  assign bus.o_valid  = (count_q != '0);
  assign bus.o_result = bus.o_valid ? mem_res_q[rd_ptr_q] : '0;
  assign bus.o_tag    = bus.o_valid ? mem_tag_q[rd_ptr_q] : '0;
endmodule
